// File: rtl/div_datapath.sv
// Signed 8/9-bit restoring divider datapath.
// A sequencer supplies one quotient bit per enabled step.
module div_datapath (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_n,
  input  logic [7:0] dividend,
  input  logic [8:0] divisor,
  input  logic       enable,
  input  logic       bit_in,
  output logic [8:0] divisor_mag,
  output logic       diff_neg,
  output logic [7:0] quotient,
  output logic [8:0] remainder,
  output logic       valid,
  output logic       busy,
  output logic       ovf
);

  logic [8:0] d_q;
  logic [7:0] q_q;
  logic [8:0] r_q;
  logic [3:0] step;
  logic       qs;
  logic       rs;

  logic [7:0] dvd_mag;
  logic [8:0] dvs_mag;
  logic [9:0] shifted;
  logic [8:0] r_sub;
  logic [7:0] q_nxt;
  logic [8:0] r_nxt;
  logic [7:0] q_sgn;
  logic [8:0] r_sgn;
  logic       load;
  logic       adv;
  logic       last;
  logic       q_ovf;

  // Unsigned magnitudes: -128 -> 8'h80, -256 -> 9'h100
  assign dvd_mag = dividend[7] ? (~dividend + 8'd1) : dividend;
  assign dvs_mag = divisor[8] ? (~divisor + 9'd1) : divisor;

  assign shifted  = {r_q, q_q[7]};
  assign diff_neg = shifted < {1'b0, d_q};
  assign r_sub    = shifted[8:0] - d_q;

  assign q_nxt = {q_q[6:0], bit_in};
  assign r_nxt = bit_in ? r_sub : shifted[8:0];
  assign q_sgn = qs ? (~q_nxt + 8'd1) : q_nxt;
  assign r_sgn = rs ? (~r_nxt + 9'd1) : r_nxt;
  assign q_ovf = (q_nxt == 8'h80) && !qs;

  assign load = !start_n && !busy;
  assign adv  = enable && busy;
  assign last = step == 4'd7;

  assign divisor_mag = d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q       <= '0;
      q_q       <= '0;
      r_q       <= '0;
      step      <= '0;
      qs        <= 1'b0;
      rs        <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (load) begin
        d_q  <= dvs_mag;
        q_q  <= dvd_mag;
        r_q  <= '0;
        step <= '0;
        qs   <= dividend[7] ^ divisor[8];
        rs   <= dividend[7];
        busy <= dvs_mag != 9'd0;
      end else if (adv) begin
        q_q  <= q_nxt;
        r_q  <= r_nxt;
        step <= step + 4'd1;
        if (last) begin
          busy      <= 1'b0;
          valid     <= 1'b1;
          ovf       <= q_ovf;
          quotient  <= q_ovf ? 8'h7F : q_sgn;
          remainder <= r_sgn;
        end
      end
    end
  end

endmodule

// File: tb/tb_div_datapath.sv
// Self-checking bench for div_datapath.
// Randomized operands against a plain-arithmetic division model.
module tb_div_datapath;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_n;
  logic [7:0] dividend;
  logic [8:0] divisor;
  logic       enable;
  logic       bit_in;
  logic [8:0] divisor_mag;
  logic       diff_neg;
  logic [7:0] quotient;
  logic [8:0] remainder;
  logic       valid;
  logic       busy;
  logic       ovf;

  int vec  = 0;
  int errs = 0;

  logic [7:0] last_q;
  logic [8:0] last_r;
  logic       last_o;

  div_datapath dut (
    .clk(clk), .rst_n(rst_n), .start_n(start_n),
    .dividend(dividend), .divisor(divisor),
    .enable(enable), .bit_in(bit_in),
    .divisor_mag(divisor_mag), .diff_neg(diff_neg),
    .quotient(quotient), .remainder(remainder),
    .valid(valid), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic void model(input int a, input int b,
                                output logic [7:0] q,
                                output logic [8:0] r,
                                output logic o);
    int qi;
    int ri;
    qi = a / b;
    ri = a % b;
    o  = (qi == 128);
    q  = o ? 8'h7F : qi[7:0];
    r  = ri[8:0];
  endfunction

  // Full division; optional busy-time reload attempt after 3 steps
  task automatic run_div(input int a, input int b, input int idle_pct,
                         input bit poke, input string tag);
    logic [7:0] eq;
    logic [8:0] er;
    logic       eo;
    logic [8:0] em;
    int steps;
    int cyc;
    int early;
    model(a, b, eq, er, eo);
    em = (b < 0) ? 9'(-b) : 9'(b);
    @(negedge clk);
    start_n = 1'b0; enable = 1'b0;
    dividend = a[7:0]; divisor = b[8:0];
    @(negedge clk);
    start_n = 1'b1;
    vec++;
    if (busy !== 1'b1 || divisor_mag !== em) begin
      errs++;
      $display("FAIL %s load: busy=%b mag=%h, need busy=1 mag=%h",
               tag, busy, divisor_mag, em);
    end
    steps = 0; cyc = 0; early = 0;
    while (steps < 8 && cyc < 200) begin
      cyc++;
      if (poke && steps == 3) begin
        start_n = 1'b0; dividend = 8'd9; divisor = 9'd3;
      end else begin
        start_n = 1'b1;
      end
      if ($urandom_range(99) < idle_pct) begin
        enable = 1'b0;
      end else begin
        enable = 1'b1;
        bit_in = !diff_neg;
        steps++;
      end
      @(negedge clk);
      if (steps < 8 && valid !== 1'b0) early++;
    end
    enable = 1'b0; start_n = 1'b1;
    vec++;
    if (cyc >= 200 || early != 0) begin
      errs++;
      $display("FAIL %s timing: cycles=%0d early_valid=%0d, need <200 and 0",
               tag, cyc, early);
    end
    vec++;
    if (valid !== 1'b1 || busy !== 1'b0) begin
      errs++;
      $display("FAIL %s done: valid=%b busy=%b, need 1 0",
               tag, valid, busy);
    end
    vec++;
    if (quotient !== eq || remainder !== er || ovf !== eo) begin
      errs++;
      $display("FAIL %s %0d/%0d result: q=%h r=%h o=%b, need q=%h r=%h o=%b",
               tag, a, b, quotient, remainder, ovf, eq, er, eo);
    end
    @(negedge clk);
    vec++;
    if (valid !== 1'b0 || quotient !== eq || remainder !== er) begin
      errs++;
      $display("FAIL %s pulse/hold: valid=%b q=%h r=%h, need 0 %h %h",
               tag, valid, quotient, remainder, eq, er);
    end
    last_q = eq; last_r = er; last_o = eo;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_n = 1'b1; enable = 1'b0; bit_in = 1'b0;
    dividend = '0; divisor = '0;
    #1;
    vec++;
    if ({quotient, remainder, valid, busy, ovf, divisor_mag, diff_neg} !== '0) begin
      errs++;
      $display("FAIL reset: q=%h r=%h v=%b b=%b o=%b m=%h dn=%b, need all 0",
               quotient, remainder, valid, busy, ovf, divisor_mag, diff_neg);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    run_div(100, 7, 0, 1'b0, "p100_7");
    run_div(-100, 7, 20, 1'b0, "m100_7");
    run_div(100, -7, 20, 1'b0, "p100_m7");
    run_div(-128, -1, 0, 1'b0, "ovf");
    run_div(-128, 1, 0, 1'b0, "m128_1");
    run_div(-128, -256, 0, 1'b0, "m256");
    run_div(127, 255, 30, 1'b0, "p127_255");
  endtask

  task automatic test_random();
    int a;
    int b;
    for (int i = 0; i < 25; i++) begin
      a = int'($urandom_range(255)) - 128;
      b = int'($urandom_range(511)) - 256;
      if (b == 0) b = 1;
      run_div(a, b, 30, 1'b0, "rand");
    end
  endtask

  task automatic test_ignore_start();
    run_div(100, 7, 0, 1'b1, "busy_start");
  endtask

  task automatic test_zero_div();
    int vcnt;
    @(negedge clk);
    start_n = 1'b0; dividend = 8'd55; divisor = 9'd0;
    @(negedge clk);
    start_n = 1'b1;
    vec++;
    if (divisor_mag !== 9'd0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL zero_load: mag=%h busy=%b, need 0 0", divisor_mag, busy);
    end
    vcnt = 0;
    for (int i = 0; i < 8; i++) begin
      enable = 1'b1; bit_in = 1'b1;
      @(negedge clk);
      if (valid !== 1'b0) vcnt++;
    end
    enable = 1'b0;
    vec++;
    if (vcnt != 0 || quotient !== last_q || remainder !== last_r || ovf !== last_o) begin
      errs++;
      $display("FAIL zero_steps: valids=%0d q=%h r=%h o=%b, need 0 %h %h %b",
               vcnt, quotient, remainder, ovf, last_q, last_r, last_o);
    end
  endtask

  // Quotient bits of 0 are obeyed even when the subtraction would fit
  task automatic test_bit_override();
    @(negedge clk);
    start_n = 1'b0; dividend = 8'(-77); divisor = 9'd5;
    @(negedge clk);
    start_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      enable = 1'b1; bit_in = 1'b0;
      @(negedge clk);
    end
    enable = 1'b0;
    vec++;
    if (valid !== 1'b1 || quotient !== 8'h00 || remainder !== 9'(-77) || ovf !== 1'b0) begin
      errs++;
      $display("FAIL override: v=%b q=%h r=%h o=%b, need 1 00 %h 0",
               valid, quotient, remainder, ovf, 9'(-77));
    end
    last_q = 8'h00; last_r = 9'(-77); last_o = 1'b0;
  endtask

  task automatic test_reset_abort();
    int vcnt;
    run_div(-100, 7, 0, 1'b0, "pre_abort");
    @(negedge clk);
    start_n = 1'b0; dividend = 8'd50; divisor = 9'd3;
    @(negedge clk);
    start_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      enable = 1'b1; bit_in = !diff_neg;
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    vec++;
    if ({quotient, remainder, valid, busy, ovf, divisor_mag, diff_neg} !== '0) begin
      errs++;
      $display("FAIL abort: q=%h r=%h v=%b b=%b o=%b m=%h dn=%b, need all 0",
               quotient, remainder, valid, busy, ovf, divisor_mag, diff_neg);
    end
    @(negedge clk);
    rst_n = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 6; i++) begin
      enable = 1'b1; bit_in = 1'b1;
      @(negedge clk);
      if (valid !== 1'b0 || busy !== 1'b0) vcnt++;
    end
    enable = 1'b0;
    vec++;
    if (vcnt != 0 || quotient !== 8'h00) begin
      errs++;
      $display("FAIL post_abort: bad_cycles=%0d q=%h, need 0 00", vcnt, quotient);
    end
    run_div(50, 3, 0, 1'b0, "reload_50_3");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_zero_div();
    test_bit_override();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
